// File: rtl/intc_16src_v1.sv
// 16-source priority interrupt controller with rising-edge capture, SFR access
// and a non-nesting IDLE/REQ/SERVICE handshake to the CPU.
module intc_16src_v1 #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'hFFFFF864),
  parameter int unsigned           N_SRC      = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [ADDR_WIDTH-1:0] sys_addr,
  input  logic                  sys_wr_en,
  input  logic [DATA_WIDTH-1:0] sys_sw_value,
  input  logic [N_SRC-1:0]      irq_src,
  input  logic                  cpu_irq_ack,
  input  logic                  cpu_irq_done,
  output logic [DATA_WIDTH-1:0] sfr_rd_dout,
  output logic                  cpu_irq_req,
  output logic [3:0]            cpu_irq_id
);

  localparam int unsigned ID_W = 4;

  localparam logic [ADDR_WIDTH-1:0] A_CTRL = BASE_ADDR;
  localparam logic [ADDR_WIDTH-1:0] A_IE   = BASE_ADDR + ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] A_IF   = BASE_ADDR + ADDR_WIDTH'(8);
  localparam logic [ADDR_WIDTH-1:0] A_STAT = BASE_ADDR + ADDR_WIDTH'(12);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_gie;
  logic [N_SRC-1:0]  r_ie;
  logic [N_SRC-1:0]  r_if;
  logic [N_SRC-1:0]  r_src_q;
  logic [ID_W-1:0]   r_active_id;
  logic              r_req;

  logic [N_SRC-1:0]  w_pend;
  logic [N_SRC-1:0]  w_set;
  logic [N_SRC-1:0]  w_w1c;
  logic [N_SRC-1:0]  w_id_mask;
  logic [N_SRC-1:0]  w_ack_clr;
  logic [ID_W-1:0]   w_low_id;
  logic [ID_W-1:0]   w_id_nxt;
  logic              w_req_nxt;
  logic              w_abort;
  logic              w_wr_ctrl;
  logic              w_wr_ie;
  logic              w_unused;

  assign w_unused  = ^sys_sw_value;
  assign w_wr_ctrl = sys_wr_en && (sys_addr == A_CTRL);
  assign w_wr_ie   = sys_wr_en && (sys_addr == A_IE);
  assign w_w1c     = (sys_wr_en && (sys_addr == A_IF)) ? sys_sw_value[N_SRC-1:0] : '0;
  assign w_set     = irq_src & ~r_src_q;
  assign w_pend    = r_if & r_ie;
  assign w_id_mask = N_SRC'(1) << r_active_id;

  // Request is withdrawn if software disables or clears the presented source
  assign w_abort = !r_gie || ((r_ie & w_id_mask) == '0) || ((r_if & w_id_mask) == '0);

  // Lowest set index wins (bit 0 = highest priority)
  always_comb begin
    w_low_id = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (w_pend[i]) w_low_id = ID_W'(i);
    end
  end

  // FSM state register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_gie && (w_pend != '0)) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (w_abort)          w_state_nxt = S_IDLE;
        else if (cpu_irq_ack) w_state_nxt = S_SERVICE;
      end
      S_SERVICE: begin
        if (cpu_irq_done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: next request/id values and the acknowledge clear mask
  always_comb begin
    w_req_nxt = (w_state_nxt == S_REQ);
    w_id_nxt  = r_active_id;
    w_ack_clr = '0;
    if (w_state_nxt == S_IDLE) begin
      w_id_nxt = '0;
    end else if (r_state == S_IDLE) begin
      w_id_nxt = w_low_id;
    end
    if ((r_state == S_REQ) && (w_state_nxt == S_SERVICE)) begin
      w_ack_clr = w_id_mask;
    end
  end

  // Registered outputs and active id
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_req       <= 1'b0;
      r_active_id <= '0;
    end else begin
      r_req       <= w_req_nxt;
      r_active_id <= w_id_nxt;
    end
  end

  // SFR state and edge capture; a hardware set beats any same-cycle clear
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_gie   <= 1'b0;
      r_ie    <= '0;
      r_if    <= '0;
      r_src_q <= '0;
    end else begin
      r_src_q <= irq_src;
      r_if    <= (r_if & ~(w_w1c | w_ack_clr)) | w_set;
      if (w_wr_ctrl) r_gie <= sys_sw_value[0];
      if (w_wr_ie)   r_ie  <= sys_sw_value[N_SRC-1:0];
    end
  end

  // Combinational read mux; zero when unaddressed so it can be OR-merged
  always_comb begin
    sfr_rd_dout = '0;
    if (sys_addr == A_CTRL) begin
      sfr_rd_dout[0] = r_gie;
    end else if (sys_addr == A_IE) begin
      sfr_rd_dout[N_SRC-1:0] = r_ie;
    end else if (sys_addr == A_IF) begin
      sfr_rd_dout[N_SRC-1:0] = r_if;
    end else if (sys_addr == A_STAT) begin
      sfr_rd_dout[ID_W-1:0] = r_active_id;
      sfr_rd_dout[8]        = (r_state == S_REQ);
      sfr_rd_dout[9]        = (r_state == S_SERVICE);
    end
  end

  assign cpu_irq_req = r_req;
  assign cpu_irq_id  = r_active_id;

endmodule
